dvs_event_queue_drain: RTL

//  Consumer end of dvs_fifo_event_queue. Pops one queued DVS event at a time,

---
 rtl/dvs_ravens_pkg.sv | 22 ++
 rtl/dvs_event_serializer.sv | 49 ++++
 rtl/dvs_event_queue_drain.sv | 91 +++++++++
 3 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS widths, flit geometry and drain FSM state encoding.
package dvs_ravens_pkg;

    localparam int EVENT_BITS        = 20;
    localparam int RAVENS_WORD_BITS  = 8;
    localparam int EVENT_QUEUE_DEPTH = 8;

    localparam int NUM_FLITS     = (EVENT_BITS + RAVENS_WORD_BITS - 1) / RAVENS_WORD_BITS;
    localparam int SHIFT_BITS    = NUM_FLITS * RAVENS_WORD_BITS;
    localparam int FLIT_CNT_BITS = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_WAIT,
        DRAIN_SEND
    } drain_state_t;

    function automatic logic is_last_flit(input logic [FLIT_CNT_BITS-1:0] cnt);
        return cnt == FLIT_CNT_BITS'(NUM_FLITS - 1);
    endfunction

endpackage

// File: rtl/dvs_event_serializer.sv
// Splits one captured event into NUM_FLITS words, MSB flit first, over valid/ready.
module dvs_event_serializer
    import dvs_ravens_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [EVENT_BITS-1:0]       event_data,
    input  logic                        tx_ready,
    output logic [RAVENS_WORD_BITS-1:0] tx_data,
    output logic                        tx_valid,
    output logic                        tx_last,
    output logic                        done
);

    logic [SHIFT_BITS-1:0]    shreg;
    logic [FLIT_CNT_BITS-1:0] flit_cnt;
    logic                     valid_q;
    logic                     last;

    assign last     = is_last_flit(flit_cnt);
    assign tx_valid = valid_q;
    assign tx_last  = valid_q & last;
    assign tx_data  = shreg[SHIFT_BITS-1 -: RAVENS_WORD_BITS];
    assign done     = valid_q & tx_ready & last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            flit_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            shreg    <= SHIFT_BITS'(event_data);
            flit_cnt <= '0;
            valid_q  <= 1'b1;
        end else if (valid_q && tx_ready) begin
            if (last) begin
                // Clear on completion so tx_data idles at zero between events.
                shreg    <= '0;
                flit_cnt <= '0;
                valid_q  <= 1'b0;
            end else begin
                shreg    <= shreg << RAVENS_WORD_BITS;
                flit_cnt <= flit_cnt + FLIT_CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/dvs_event_queue_drain.sv
// Consumer end of the DVS event queue: pop, wait out SRAM latency, serialize to RAVENS.
//
//  state      | meaning
//  DRAIN_IDLE | ready to pop; q_rd_en when enabled, non-empty and no write
//  DRAIN_WAIT | popped; counting down SRAM read latency, then capture
//  DRAIN_SEND | serializer streaming flits until the last one is accepted
module dvs_event_queue_drain
    import dvs_ravens_pkg::*;
#(
    parameter int SRAM_RD_LATENCY = 1,
    parameter int COUNT_BITS      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        q_empty,
    input  logic                        q_wr_en,
    output logic                        q_rd_en,
    input  logic [EVENT_BITS-1:0]       q_event,
    output logic [RAVENS_WORD_BITS-1:0] tx_data,
    output logic                        tx_valid,
    output logic                        tx_last,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic [COUNT_BITS-1:0]       sent_count
);

    localparam int LAT_W = (SRAM_RD_LATENCY > 1) ? $clog2(SRAM_RD_LATENCY) : 1;

    drain_state_t     state;
    drain_state_t     state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             pop;
    logic             load;
    logic             done;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                // rst_n gating keeps the pop strobe quiet while reset is held.
                pop = rst_n & enable & ~q_empty & ~q_wr_en;
                if (pop) state_nxt = DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
                if (lat_cnt == '0) begin
                    load      = 1'b1;
                    state_nxt = DRAIN_SEND;
                end
            end
            DRAIN_SEND: begin
                if (done) state_nxt = DRAIN_IDLE;
            end
            default: state_nxt = DRAIN_IDLE;
        endcase
    end

    assign q_rd_en = pop;
    assign busy    = (state != DRAIN_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRAIN_IDLE;
            lat_cnt    <= '0;
            sent_count <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                lat_cnt <= LAT_W'(SRAM_RD_LATENCY - 1);
            else if (state == DRAIN_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - LAT_W'(1);
            if (done)
                sent_count <= sent_count + COUNT_BITS'(1);
        end
    end

    dvs_event_serializer u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .event_data (q_event),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .done       (done)
    );

endmodule
